// File: rtl/gmlp_pkg.sv
// Shared fixed-point constants, FSM encoding and slice helper for the gMLP datapath.
package gmlp_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned FRAC_BITS_DEF  = 8;

  localparam int unsigned ONE        = 1 << FRAC_BITS_DEF;
  localparam int unsigned HALF       = 1 << (FRAC_BITS_DEF - 1);
  localparam int unsigned GELU_LIMIT = 2 << FRAC_BITS_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } gelu_state_e;

  // LSB position of element idx in a flat vector of w-bit elements.
  function automatic int unsigned slice_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/gelu_pwl_lane.sv
// Two-stage hard-GELU lane: stage 1 clamps h = 0.5 + x/4, stage 2 (registered by the caller) is y = x*h scaled.
// GELU_ROUND_EN selects round-half-up instead of floor for the final shift.
module gelu_pwl_lane
  import gmlp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
  parameter int unsigned IDX_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [IDX_W-1:0]             in_idx,
  input  logic signed [DATA_WIDTH-1:0] in_x,
  output logic                         out_valid_c,
  output logic [IDX_W-1:0]             out_idx_c,
  output logic signed [DATA_WIDTH-1:0] out_y_c
);

  localparam int unsigned EXT_W  = DATA_WIDTH + 2;
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;

  localparam logic signed [EXT_W-1:0]  ONE_E  = EXT_W'(1) << FRAC_BITS;
  localparam logic signed [EXT_W-1:0]  HALF_E = EXT_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [PROD_W-1:0] RND    = PROD_W'(1) << (FRAC_BITS - 1);

  logic signed [EXT_W-1:0]      x_ext;
  logic signed [EXT_W-1:0]      h_sum;
  logic signed [EXT_W-1:0]      h_clamp;
  logic                         valid_q;
  logic [IDX_W-1:0]             idx_q;
  logic signed [DATA_WIDTH-1:0] x_q;
  logic signed [DATA_WIDTH-1:0] h_q;
  logic signed [PROD_W-1:0]     prod;
  logic signed [PROD_W-1:0]     prod_adj;

  // Slope term evaluated two bits wider so the offset add cannot wrap before clamping.
  always_comb begin
    x_ext = EXT_W'(in_x);
    h_sum = HALF_E + (x_ext >>> 2);
    if (h_sum < 0) begin
      h_clamp = '0;
    end else if (h_sum > ONE_E) begin
      h_clamp = ONE_E;
    end else begin
      h_clamp = h_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      x_q     <= '0;
      h_q     <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        idx_q <= in_idx;
        x_q   <= in_x;
        h_q   <= DATA_WIDTH'(h_clamp);
      end
    end
  end

  // |h| <= 1.0 keeps |y| <= |x|, so truncating to DATA_WIDTH never saturates.
  always_comb begin
    prod = PROD_W'(x_q) * PROD_W'(h_q);
`ifdef GELU_ROUND_EN
    prod_adj = prod + RND;
`else
    prod_adj = prod;
`endif
    out_y_c     = DATA_WIDTH'(prod_adj >>> FRAC_BITS);
    out_valid_c = valid_q;
    out_idx_c   = idx_q;
  end

endmodule

// File: rtl/gelu_activation.sv
// Elementwise hard-GELU stage after proj_in: one element per cycle, start/done handshake.
// Build option GELU_ROUND_EN (in gelu_pwl_lane) rounds the final shift half up.
module gelu_activation
  import gmlp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned FRAC_BITS  = FRAC_BITS_DEF,
  parameter int unsigned DIM        = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [DIM*DATA_WIDTH-1:0] in_vector,
  output logic [DIM*DATA_WIDTH-1:0] out_vector,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned VEC_W = DIM * DATA_WIDTH;

  gelu_state_e             state;
  logic [VEC_W-1:0]        in_reg;
  logic [IDX_W-1:0]        index;
  logic                    issue_valid_c;
  logic [DATA_WIDTH-1:0]   issue_x_c;
  logic                    lane_valid_c;
  logic [IDX_W-1:0]        lane_idx_c;
  logic signed [DATA_WIDTH-1:0] lane_y_c;

  always_comb begin
    issue_valid_c = (state == ST_ISSUE);
    issue_x_c     = '0;
    for (int unsigned i = 0; i < DIM; i++) begin
      if (index == IDX_W'(i)) begin
        issue_x_c = in_reg[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  gelu_pwl_lane #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS),
    .IDX_W      (IDX_W)
  ) u_lane (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (issue_valid_c),
    .in_idx      (index),
    .in_x        (issue_x_c),
    .out_valid_c (lane_valid_c),
    .out_idx_c   (lane_idx_c),
    .out_y_c     (lane_y_c)
  );

  // Control FSM plus stage-2 write-back into out_vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      in_reg     <= '0;
      index      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_vector <= '0;
    end else begin
      done <= 1'b0;
      for (int unsigned i = 0; i < DIM; i++) begin
        if (lane_valid_c && (lane_idx_c == IDX_W'(i))) begin
          out_vector[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH] <= lane_y_c;
        end
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            in_reg <= in_vector;
            index  <= '0;
            busy   <= 1'b1;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          index <= index + IDX_W'(1);
          if (index == IDX_W'(DIM - 1)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gelu_activation.sv
// Directed self-checking bench for gelu_activation, including a behavioural upstream linear layer.
module tb_gelu_activation;
  import gmlp_pkg::*;

  localparam int unsigned DW  = 16;
  localparam int unsigned DIM = 4;
  localparam int unsigned VW  = DW * DIM;

  logic          clk;
  logic          rst;
  logic          start;
  logic [VW-1:0] in_vector;
  logic [VW-1:0] out_vector;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  gelu_activation #(
    .DATA_WIDTH (DW),
    .FRAC_BITS  (8),
    .DIM        (DIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_vector  (in_vector),
    .out_vector (out_vector),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start with vec, scramble inputs afterwards, wait for done.
  task automatic run_vec(input logic [VW-1:0] vec, output int lat, output int busy_cyc);
    in_vector = vec;
    start = 1'b1;
    step();
    start = 1'b0;
    in_vector = {$urandom, $urandom};
    lat = 0;
    busy_cyc = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cyc++;
      step();
      lat++;
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done) n++;
      step();
    end
  endtask

  function automatic logic [DW-1:0] gelu_ref(input logic [DW-1:0] xv);
    int x, h, p;
    x = int'($signed(xv));
    h = 128 + (x >>> 2);
    if (h < 0) h = 0;
    if (h > int'(ONE)) h = int'(ONE);
    p = x * h;
`ifdef GELU_ROUND_EN
    p = p + 128;
`endif
    return DW'(p >>> 8);
  endfunction

  function automatic logic [VW-1:0] gelu_vec_ref(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DIM); i++) r[i*DW +: DW] = gelu_ref(v[i*DW +: DW]);
    return r;
  endfunction

  // Upstream proj_in model: out[r] = sum_c W[r][c]*x[c] >>> 8, Q8.8.
  function automatic logic [VW-1:0] linear_ref(input int w [16], input int x [4]);
    logic [VW-1:0] r;
    int acc;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      acc = 0;
      for (int c = 0; c < 4; c++) acc += w[row*4 + c] * x[c];
      r[row*DW +: DW] = DW'(acc >>> 8);
    end
    return r;
  endfunction

  initial begin
    int lat, bc, nd;
    logic [VW-1:0] v1, v2, exp_v, lin;
    int w [16];
    int xa [4];

    rst = 1'b1;
    start = 1'b0;
    in_vector = '0;
    step();
    step();
    check("reset_out", out_vector, '0);
    check("reset_busy", VW'(busy), '0);
    check("reset_done", VW'(done), '0);
    rst = 1'b0;
    step();

    // Basic vector
    run_vec({16'hFD00, 16'hFF00, 16'h0080, 16'h0100}, lat, bc);
    check("basic_out", out_vector, {16'h0000, 16'hFFC0, 16'h0050, 16'h00C0});
    check("basic_latency", VW'(lat), VW'(5));
    check("basic_busy_cycles", VW'(bc), VW'(5));
    check("basic_busy_at_done", VW'(busy), '0);
    step();
    check("done_one_cycle", VW'(done), '0);
    check("out_holds", out_vector, {16'h0000, 16'hFFC0, 16'h0050, 16'h00C0});

    // Saturation ends
    run_vec({16'h8000, 16'h7FFF, 16'h0300, 16'hFE00}, lat, bc);
    check("sat_out", out_vector, {16'h0000, 16'h7FFF, 16'h0300, 16'h0000});
    step();

    // Rounding of the half-LSB product
    run_vec({16'h0000, 16'h0000, 16'h0000, 16'h0001}, lat, bc);
`ifdef GELU_ROUND_EN
    check("round_out", out_vector, {48'h0, 16'h0001});
`else
    check("round_out", out_vector, {48'h0, 16'h0000});
`endif
    step();

    // Second start while busy is ignored
    v1 = {16'h0100, 16'h0200, 16'hFF80, 16'h0040};
    in_vector = v1;
    start = 1'b1;
    step();
    start = 1'b0;
    in_vector = {16'h0300, 16'h0300, 16'h0300, 16'h0300};
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    count_done(14, nd);
    check("ignored_start_done_count", VW'(nd), VW'(1));
    check("ignored_start_out", out_vector, gelu_vec_ref(v1));

    // Start in the done cycle: back-to-back acceptance
    v2 = {16'hFF40, 16'h0180, 16'h0010, 16'hFC00};
    run_vec(v1, lat, bc);
    check("b2b_first_done", VW'(done), VW'(1));
    run_vec(v2, lat, bc);
    check("b2b_second_latency", VW'(lat), VW'(5));
    check("b2b_second_out", out_vector, gelu_vec_ref(v2));
    step();

    // Reset in the middle of ISSUE aborts the run
    in_vector = v1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("abort_out", out_vector, '0);
    check("abort_busy", VW'(busy), '0);
    check("abort_done", VW'(done), '0);
    rst = 1'b0;
    count_done(10, nd);
    check("abort_no_done", VW'(nd), '0);
    run_vec(v2, lat, bc);
    check("after_abort_out", out_vector, gelu_vec_ref(v2));
    check("after_abort_latency", VW'(lat), VW'(5));
    step();

    // Chained after a behavioural linear layer
    w = '{256, -128, 64, 0,   -256, 512, 0, 128,   32, 32, 32, 32,   0, -64, 256, -512};
    xa = '{384, -200, 100, 50};
    lin = linear_ref(w, xa);
    run_vec(lin, lat, bc);
    check("chain0_out", out_vector, gelu_vec_ref(lin));
    xa = '{-600, 700, -50, 300};
    lin = linear_ref(w, xa);
    run_vec(lin, lat, bc);
    check("chain1_out", out_vector, gelu_vec_ref(lin));
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
